// File: rtl/ir_command_scheduler.sv
// ir_command_scheduler: debounces four direction buttons into a 4-bit command,
// generates the periodic packet trigger and holds the command stable for the
// whole packet using the transmitter busy handshake.
module ir_command_scheduler #(
  parameter int CLK_FREQ        = 100_000_000,
  parameter int PACKET_RATE_HZ  = 10,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BUSY_TIMEOUT    = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTN_FWD,
  input  logic       BTN_BACK,
  input  logic       BTN_LEFT,
  input  logic       BTN_RIGHT,
  input  logic       TX_BUSY,
  output logic [3:0] COMMAND,
  output logic       SEND_PACKET,
  output logic       OVERRUN,
  output logic       TIMEOUT_ERR
);

  localparam int PERIOD = CLK_FREQ / PACKET_RATE_HZ;
  localparam int PER_W  = $clog2(PERIOD + 1);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W   = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BUSY = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  // Bit order everywhere: {fwd, back, left, right}
  logic [3:0]      w_btn;
  logic [3:0]      r_sync1;
  logic [3:0]      r_sync2;
  logic [3:0]      r_acc;
  logic [DB_W-1:0] r_db_cnt [4];
  logic [3:0]      w_cand;

  logic [PER_W-1:0] r_rate_cnt;
  logic             w_tick;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_pending;
  logic [TO_W-1:0]  r_to_cnt;
  logic             w_go;
  logic             w_send;
  logic             w_timeout;
  logic             w_overrun;
  logic             w_pending_nxt;
  logic             w_to_run;

  assign w_btn = {BTN_FWD, BTN_BACK, BTN_LEFT, BTN_RIGHT};

  // Two-flop synchronizer for the raw asynchronous buttons
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Per-button debouncer: accept a new level only after it has been stable long enough
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_acc <= '0;
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] != r_acc[i]) begin
          if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            r_acc[i]    <= r_sync2[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  // Opposing directions on the same axis cancel each other
  assign w_cand = {r_acc[3] & ~r_acc[2], r_acc[2] & ~r_acc[3],
                   r_acc[1] & ~r_acc[0], r_acc[0] & ~r_acc[1]};

  // Free-running packet-rate counter; tick marks its last count
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_rate_cnt <= '0;
    end else if (w_tick) begin
      r_rate_cnt <= '0;
    end else begin
      r_rate_cnt <= r_rate_cnt + PER_W'(1);
    end
  end

  assign w_tick = (r_rate_cnt == PER_W'(PERIOD - 1));
  assign w_go   = w_tick | r_pending;

  // Scheduler state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Scheduler next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_go) w_state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (TX_BUSY)        w_state_nxt = S_WAIT_DONE;
        else if (w_timeout) w_state_nxt = S_IDLE;
      end
      S_WAIT_DONE: if (!TX_BUSY) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Scheduler control outputs; a tick with one already queued is always an overrun
  always_comb begin
    w_send        = 1'b0;
    w_timeout     = 1'b0;
    w_to_run      = 1'b0;
    w_overrun     = w_tick & r_pending;
    w_pending_nxt = r_pending;
    case (r_state)
      S_IDLE: begin
        w_send = w_go;
        if (w_go) w_pending_nxt = 1'b0;
      end
      S_WAIT_BUSY: begin
        w_timeout = !TX_BUSY && (r_to_cnt == TO_W'(BUSY_TIMEOUT - 1));
        w_to_run  = !TX_BUSY && !w_timeout;
        if (w_tick) w_pending_nxt = 1'b1;
      end
      default: begin
        if (w_tick) w_pending_nxt = 1'b1;
      end
    endcase
  end

  // Registered trigger, command capture, pending tick, timeout counter and sticky flags
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      SEND_PACKET <= 1'b0;
      COMMAND     <= '0;
      r_pending   <= 1'b0;
      r_to_cnt    <= '0;
      OVERRUN     <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      SEND_PACKET <= w_send;
      if (w_send) COMMAND <= w_cand;
      r_pending   <= w_pending_nxt;
      r_to_cnt    <= w_to_run ? r_to_cnt + TO_W'(1) : '0;
      if (w_overrun) OVERRUN     <= 1'b1;
      if (w_timeout) TIMEOUT_ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ir_command_scheduler.sv
// Directed bench for ir_command_scheduler with a send scoreboard and a
// simple transmitter model that raises TX_BUSY for a programmable time.
module tb_ir_command_scheduler;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       BTN_FWD = 1'b0;
  logic       BTN_BACK = 1'b0;
  logic       BTN_LEFT = 1'b0;
  logic       BTN_RIGHT = 1'b0;
  logic       TX_BUSY = 1'b0;
  logic [3:0] COMMAND;
  logic       SEND_PACKET;
  logic       OVERRUN;
  logic       TIMEOUT_ERR;

  typedef struct {
    int         cyc;
    logic [3:0] cmd;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         vectors = 0;
  int         errors = 0;
  int         tx_n = 30;
  bit         tx_en = 1'b1;
  int         tx_cnt = 0;
  logic [3:0] exp_cmd = 4'b0000;
  logic       prev_send = 1'b0;

  ir_command_scheduler #(
    .CLK_FREQ(1000),
    .PACKET_RATE_HZ(10),
    .DEBOUNCE_CYCLES(4),
    .BUSY_TIMEOUT(8)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .BTN_FWD(BTN_FWD),
    .BTN_BACK(BTN_BACK),
    .BTN_LEFT(BTN_LEFT),
    .BTN_RIGHT(BTN_RIGHT),
    .TX_BUSY(TX_BUSY),
    .COMMAND(COMMAND),
    .SEND_PACKET(SEND_PACKET),
    .OVERRUN(OVERRUN),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int c, input logic [3:0] cmd);
    exp_t e;
    e.cyc = c;
    e.cmd = cmd;
    q.push_back(e);
  endtask

  task automatic run_to(input int n);
    do @(negedge CLK); while (cyc < n);
    #2;
  endtask

  task automatic end_scn(input string tag);
    check(tag, q.size(), 0);
    q.delete();
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    #1;
    check("rst_command", COMMAND, 4'b0000);
    check("rst_send", SEND_PACKET, 1'b0);
    check("rst_overrun", OVERRUN, 1'b0);
    check("rst_timeout", TIMEOUT_ERR, 1'b0);
    q.delete();
    repeat (3) @(negedge CLK);
    #2;
    RESET = 1'b1;
  endtask

  // Cycle counter, transmitter model and scoreboard checker
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      if (!RESET) cyc = 0;
      else        cyc++;
      @(negedge CLK);
      if (!RESET) begin
        exp_cmd   = 4'b0000;
        prev_send = 1'b0;
        TX_BUSY   = 1'b0;
        tx_cnt    = 0;
      end else begin
        if (SEND_PACKET) begin
          check("send_width", prev_send, 1'b0);
          vectors++;
          assert (q.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_send observed_cycle=%0d expected=none", cyc);
          end
          if (q.size() > 0) begin
            e = q.pop_front();
            check("send_cycle", cyc, e.cyc);
            check("send_cmd", COMMAND, e.cmd);
            exp_cmd = e.cmd;
          end
        end else begin
          check("cmd_hold", COMMAND, exp_cmd);
        end
        prev_send = SEND_PACKET;
        if (tx_cnt > 0) begin
          tx_cnt--;
          if (tx_cnt == 0) TX_BUSY = 1'b0;
        end
        if (SEND_PACKET && tx_en) begin
          TX_BUSY = 1'b1;
          tx_cnt  = tx_n;
        end
      end
    end
  end

  initial begin
    #2;
    do_reset();

    // Periodic trigger with forward held
    BTN_FWD = 1'b1;
    push(100, 4'b1000);
    push(200, 4'b1000);
    push(300, 4'b1000);
    run_to(305);
    check("periodic_overrun", OVERRUN, 1'b0);
    check("periodic_timeout", TIMEOUT_ERR, 1'b0);
    end_scn("periodic_q_empty");

    // Debounce: bouncing left is never accepted, a steady hold is
    BTN_FWD = 1'b0;
    do_reset();
    push(100, 4'b0000);
    push(200, 4'b0010);
    for (int i = 0; i < 60; i++) begin
      BTN_LEFT = ~BTN_LEFT;
      run_to(cyc + 2);
    end
    BTN_LEFT = 1'b1;
    run_to(205);
    end_scn("debounce_q_empty");

    // Conflicts on each axis
    BTN_LEFT = 1'b0;
    do_reset();
    BTN_FWD   = 1'b1;
    BTN_BACK  = 1'b1;
    BTN_RIGHT = 1'b1;
    push(100, 4'b0001);
    push(200, 4'b0000);
    run_to(105);
    BTN_LEFT = 1'b1;
    run_to(205);
    end_scn("conflict_q_empty");

    // Deferred send after a long packet, no overrun
    BTN_FWD = 1'b0; BTN_LEFT = 1'b0; BTN_RIGHT = 1'b0; BTN_BACK = 1'b1;
    tx_n = 150;
    do_reset();
    push(100, 4'b0100);
    push(252, 4'b0100);
    run_to(256);
    check("defer_overrun", OVERRUN, 1'b0);
    end_scn("defer_q_empty");

    // Overrun: second queued tick is dropped, one deferred send only
    tx_n = 250;
    do_reset();
    push(100, 4'b0100);
    push(352, 4'b0100);
    run_to(299);
    check("overrun_before", OVERRUN, 1'b0);
    run_to(300);
    check("overrun_set", OVERRUN, 1'b1);
    run_to(360);
    check("overrun_sticky", OVERRUN, 1'b1);
    end_scn("overrun_q_empty");

    // Busy never rises: timeout, then the next tick still sends
    BTN_BACK = 1'b0; BTN_RIGHT = 1'b1;
    tx_en = 1'b0;
    tx_n  = 30;
    do_reset();
    push(100, 4'b0001);
    push(200, 4'b0001);
    run_to(107);
    check("timeout_early", TIMEOUT_ERR, 1'b0);
    run_to(108);
    check("timeout_set", TIMEOUT_ERR, 1'b1);
    run_to(205);
    check("timeout_sticky", TIMEOUT_ERR, 1'b1);
    check("timeout_no_overrun", OVERRUN, 1'b0);
    end_scn("timeout_q_empty");

    // Command stability during a packet, then reset mid-packet
    tx_en = 1'b1;
    tx_n  = 60;
    do_reset();
    push(100, 4'b0001);
    push(200, 4'b1000);
    run_to(120);
    BTN_RIGHT = 1'b0;
    BTN_FWD   = 1'b1;
    run_to(220);
    check("midpkt_busy", TX_BUSY, 1'b1);
    end_scn("stable_q_empty");
    do_reset();
    push(100, 4'b1000);
    run_to(105);
    end_scn("post_reset_q_empty");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
